// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the BUBBLE datapath.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module multicycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic [5:0]       alu_op,
    output logic [5:0]       funct,
    output logic             alu_en,
    input  logic             alu_zero,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             rf_we,
    output logic             rf_dst_sel,
    output logic             wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             retire,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_BAD    = 3'd7
    } state_t;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Opcode table, index = class: 0 R, 1 addi, 2 lw, 3 sw, 4 beq, 5 bne, 6 j
    localparam logic [6:0][5:0] OPCODES = {
        6'b000010, 6'b000101, 6'b000100, 6'b101011, 6'b100011, 6'b001000, 6'b000000
    };

    state_t           state_reg, state_next;
    logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [31:0]      ir_reg;
    logic             ir_load;
    logic             retire_now;
    logic [6:0]       op_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_opdec
            assign op_hit[gi] = (ir_reg[31:26] == OPCODES[gi]);
        end
    endgenerate

    logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j;
    assign is_r    = op_hit[0];
    assign is_addi = op_hit[1];
    assign is_lw   = op_hit[2];
    assign is_sw   = op_hit[3];
    assign is_beq  = op_hit[4];
    assign is_bne  = op_hit[5];
    assign is_j    = op_hit[6];

    always_comb begin
        state_next   = state_reg;
        tmo_cnt_next = tmo_cnt_reg;
        ir_load      = 1'b0;
        retire_now   = 1'b0;
        imem_req     = 1'b0;
        alu_en       = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        rf_dst_sel   = 1'b0;
        wb_sel       = 1'b0;
        pc_sel       = 2'd0;
        halted       = 1'b0;
        err          = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next   = S_FETCH;
                    tmo_cnt_next = '0;
                end
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack on the last permitted cycle still completes the fetch
                if (imem_ack) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next = S_HALT;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_DECODE: begin
                state_next = (|op_hit) ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                alu_en = 1'b1;
                if (is_r || is_addi) begin
                    state_next = S_WB;
                end else if (is_lw || is_sw) begin
                    state_next   = S_MEM;
                    tmo_cnt_next = '0;
                end else begin
                    retire_now = 1'b1;
                    if (is_j)
                        pc_sel = 2'd2;
                    else if ((is_beq && alu_zero) || (is_bne && !alu_zero))
                        pc_sel = 2'd1;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (dmem_ack) begin
                    if (is_sw)
                        retire_now = 1'b1;
                    else
                        state_next = S_WB;
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    state_next = S_HALT;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                rf_dst_sel = is_r;
                wb_sel     = is_lw;
                retire_now = 1'b1;
            end
            default: begin
                // HALT is only reached on an error; the unused encoding is treated the same
                halted = 1'b1;
                err    = 1'b1;
            end
        endcase

        if (retire_now) begin
            state_next   = stop ? S_IDLE : S_FETCH;
            tmo_cnt_next = '0;
        end
    end

    assign pc_we  = retire_now;
    assign retire = retire_now;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            tmo_cnt_reg <= '0;
            ir_reg      <= '0;
        end else begin
            state_reg   <= state_next;
            tmo_cnt_reg <= tmo_cnt_next;
            if (ir_load)
                ir_reg <= imem_rdata;
        end
    end

    assign ir     = ir_reg;
    assign alu_op = ir_reg[31:26];
    assign funct  = ir_reg[5:0];
    assign state  = state_reg;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n)
            retired_cnt_reg <= '0;
        else if (retire_now && (retired_cnt_reg != {CNT_W{1'b1}}))
            retired_cnt_reg <= retired_cnt_reg + 1'b1;
    end

    assign retired_cnt = retired_cnt_reg;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; each instruction walked cycle by cycle.
module tb_multicycle_sequencer;

    localparam int CNT_W = 32;
`ifdef SEQ_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, start, stop;
    logic             imem_req, imem_ack;
    logic [31:0]      imem_rdata, ir;
    logic [5:0]       alu_op, funct;
    logic             alu_en, alu_zero;
    logic             dmem_req, dmem_we, dmem_ack;
    logic             rf_we, rf_dst_sel, wb_sel, pc_we, retire, halted, err;
    logic [1:0]       pc_sel;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired_cnt;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .alu_op(alu_op), .funct(funct), .alu_en(alu_en), .alu_zero(alu_zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .rf_dst_sel(rf_dst_sel), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
        .halted(halted), .err(err), .state(state), .retired_cnt(retired_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: pulse start, land in the FETCH cycle
    task automatic begin_instr();
        start = 1'b1;
        #1;
        chk("idle_state", 32'(state), 32'd0);
        tick();
        start = 1'b0;
    endtask

    // In FETCH: ack in the same cycle, land in DECODE
    task automatic fetch(input logic [31:0] word);
        imem_ack   = 1'b1;
        imem_rdata = word;
        #1;
        chk("fetch_state", 32'(state), 32'd1);
        chk("fetch_req", 32'(imem_req), 32'd1);
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; alu_zero = 1'b0; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_strobes", {imem_req, alu_en, dmem_req, rf_we, pc_we, retire, halted, err}, 32'd0);
        chk("rst_pc_sel", 32'(pc_sel), 32'd0);
        chk("rst_cnt", retired_cnt, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_hold", 32'(state), 32'd0);

        // add r2,r1,r2 : alu_en cycle 3, WB cycle 4
        begin_instr();
        fetch(32'h0022_1020);
        chk("add_decode", 32'(state), 32'd2);
        chk("add_ir", ir, 32'h0022_1020);
        chk("add_funct", 32'(funct), 32'h20);
        chk("add_alu_op", 32'(alu_op), 32'h00);
        chk("add_dec_alu_en", 32'(alu_en), 32'd0);
        tick();
        chk("add_exec_alu_en", 32'(alu_en), 32'd1);
        chk("add_exec_retire", 32'(retire), 32'd0);
        tick();
        chk("add_wb", {rf_we, rf_dst_sel, wb_sel, pc_we, retire}, 32'b11011);
        chk("add_wb_pc_sel", 32'(pc_sel), 32'd0);
        tick();

        // lw with dmem_ack three cycles late
        fetch(32'h8C22_0004);
        chk("lw_dec_alu_en", 32'(alu_en), 32'd0);
        tick();
        chk("lw_exec", {alu_en, retire, dmem_req}, 32'b100);
        tick();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #1;
            chk("lw_mem_req", {dmem_req, dmem_we, retire, rf_we}, 32'b1000);
            tick();
        end
        dmem_ack = 1'b0;
        #1;
        chk("lw_wb", {rf_we, rf_dst_sel, wb_sel, pc_we, retire}, 32'b10111);
        chk("lw_wb_dmem_req", 32'(dmem_req), 32'd0);
        tick();

        // sw, ack in first MEM cycle -> retire from MEM
        fetch(32'hAC22_0004);
        tick();
        tick();
        dmem_ack = 1'b1;
        #1;
        chk("sw_mem", {dmem_req, dmem_we, pc_we, retire, rf_we}, 32'b11110);
        chk("sw_pc_sel", 32'(pc_sel), 32'd0);
        tick();
        dmem_ack = 1'b0;

        // bne taken / not taken
        fetch(32'h1441_0001);
        tick();
        alu_zero = 1'b0;
        #1;
        chk("bne_nz_pc_sel", 32'(pc_sel), 32'd1);
        chk("bne_nz_strobes", {alu_en, pc_we, retire, rf_we}, 32'b1110);
        tick();
        fetch(32'h1441_0001);
        tick();
        alu_zero = 1'b1;
        #1;
        chk("bne_z_pc_sel", 32'(pc_sel), 32'd0);
        chk("bne_z_strobes", {pc_we, retire, rf_we}, 32'b110);
        tick();
        alu_zero = 1'b0;
        chk("cnt_after_5", retired_cnt, CNT_ON ? 32'd5 : 32'd0);

        // j with stop at retire -> IDLE
        fetch(32'h0800_0400);
        tick();
        stop = 1'b1;
        #1;
        chk("j_pc_sel", 32'(pc_sel), 32'd2);
        chk("j_strobes", {pc_we, retire, rf_we}, 32'b110);
        tick();
        stop = 1'b0;
        chk("j_stop_idle", 32'(state), 32'd0);
        tick();
        chk("idle_no_start", 32'(state), 32'd0);

        // beq taken, stop -> IDLE
        begin_instr();
        fetch(32'h1022_0003);
        tick();
        alu_zero = 1'b1;
        stop = 1'b1;
        #1;
        chk("beq_z_pc_sel", 32'(pc_sel), 32'd1);
        chk("beq_retire", 32'(retire), 32'd1);
        tick();
        alu_zero = 1'b0;
        stop = 1'b0;
        chk("beq_idle", 32'(state), 32'd0);
        chk("cnt_after_7", retired_cnt, CNT_ON ? 32'd7 : 32'd0);

        // invalid opcode -> HALT with err, sticky even with start
        begin_instr();
        fetch(32'hFC00_0000);
        chk("bad_dec_no_pc_we", {pc_we, retire}, 32'd0);
        tick();
        chk("bad_halt_state", 32'(state), 32'd6);
        chk("bad_halt_flags", {halted, err, pc_we, retire}, 32'b1100);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("halt_sticky", 32'(state), 32'd6);

        // fetch timeout: 16 cycles of FETCH, then HALT
        do_reset();
        chk("rst_from_halt", {29'd0, state}, 32'd0);
        chk("rst_clears_cnt", retired_cnt, 32'd0);
        begin_instr();
        for (int i = 0; i < 16; i++) begin
            chk("tmo_req_held", {state, imem_req}, {28'd0, 3'd1, 1'b1});
            tick();
        end
        chk("tmo_halt_state", 32'(state), 32'd6);
        chk("tmo_flags", {halted, err, imem_req}, 32'b110);

        // ack on the last permitted fetch cycle wins
        do_reset();
        begin_instr();
        repeat (15) tick();
        fetch(32'h0800_0400);
        chk("tmo_last_ack", {state, err}, {28'd0, 3'd2, 1'b0});

        // reset while in MEM
        do_reset();
        begin_instr();
        fetch(32'h8C22_0004);
        tick();
        tick();
        chk("mem_before_rst", {state, dmem_req}, {28'd0, 3'd4, 1'b1});
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mem_rst_state", 32'(state), 32'd0);
        chk("mem_rst_ir", ir, 32'd0);
        chk("mem_rst_strobes", {dmem_req, rf_we, pc_we, retire, halted, err, alu_en}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
